// File: rtl/spi_sclk_gen.sv
// SPI serial-clock front end: programmable SCLK divider gated by chip-select,
// plus a 3-flop synchronizer turning an incoming SCLK line into edge strobes.
module spi_sclk_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] divider,
  input  logic       cpol,
  input  logic       cs,
  input  logic       sig,
  output logic       sclk,
  output logic       pe,
  output logic       ne
);

  logic [6:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;
  logic       s1_q, s2_q, s3_q;
  logic [6:0] term;

  // Terminal count 2^divider - 1 without needing an 8-bit intermediate.
  assign term = 7'h7F >> (3'd7 - divider);

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (cs) begin
      cnt_d  = 7'd0;
      sclk_d = cpol;
    end else if (cnt_q >= term) begin
      // >= rather than == so a shrinking divider toggles at once instead of wrapping.
      cnt_d  = 7'd0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= 7'd0;
      sclk_q <= 1'b0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
      s1_q   <= sig;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
    end
  end

  // s1 absorbs metastability; strobes compare the two settled stages.
  assign sclk = sclk_q;
  assign pe   = s2_q & ~s3_q;
  assign ne   = ~s2_q & s3_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen: divider timing, cs abort, loopback strobes,
// divider shrink, glitch handling and asynchronous reset.
module tb_spi_sclk_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] divider;
  logic       cpol;
  logic       cs;
  logic       sig_drv;
  logic       loop_en;
  logic       sig;
  logic       sclk;
  logic       pe;
  logic       ne;

  int total = 0;
  int bad   = 0;
  int pe_cnt, ne_cnt, overlap;

  assign sig = loop_en ? sclk : sig_drv;

  spi_sclk_gen dut (
    .clk     (clk),
    .rst     (rst),
    .divider (divider),
    .cpol    (cpol),
    .cs      (cs),
    .sig     (sig),
    .sclk    (sclk),
    .pe      (pe),
    .ne      (ne)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; divider = 3'd0; cpol = 1'b1; cs = 1'b1; sig_drv = 1'b0; loop_en = 1'b0;

    // Reset and idle polarity
    step(); step();
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_pe", int'(pe), 0);
    chk("rst_ne", int'(ne), 0);
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("idle_sclk", int'(sclk), 1);
      chk("idle_pe", int'(pe), 0);
      chk("idle_ne", int'(ne), 0);
    end

    // divider=2: rise at k+4, fall at k+8, abort after k+10
    divider = 3'd2; cpol = 1'b0;
    step();
    chk("t2_idle", int'(sclk), 0);
    cs = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("t2_sclk", int'(sclk), (i >= 4 && i < 8) ? 1 : 0);
    end
    cs = 1'b1;
    for (int i = 11; i <= 14; i++) begin
      step();
      chk("t2_abort", int'(sclk), 0);
    end

    // Loopback at clk/2 with cpol=1
    divider = 3'd0; cpol = 1'b1; loop_en = 1'b1;
    repeat (4) step();
    chk("t3_idle_sclk", int'(sclk), 1);
    chk("t3_idle_pe", int'(pe), 0);
    chk("t3_idle_ne", int'(ne), 0);
    cs = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("t3_sclk", int'(sclk), (i % 2 == 1) ? 0 : 1);
      chk("t3_pe", int'(pe), (i >= 4 && i % 2 == 0) ? 1 : 0);
      chk("t3_ne", int'(ne), (i >= 3 && i % 2 == 1) ? 1 : 0);
    end
    cs = 1'b1; loop_en = 1'b0;

    // divider 7 -> 1 at cnt=50: immediate toggle, then every 2 cycles
    cpol = 1'b0; divider = 3'd7;
    repeat (4) step();
    cs = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (i == 50) chk("t4_hold", int'(sclk), 0);
    end
    divider = 3'd1;
    for (int j = 1; j <= 6; j++) begin
      step();
      chk("t4_fast", int'(sclk), ((j + 1) >> 1) & 1);
    end
    cs = 1'b1;
    step();
    chk("t4_abort", int'(sclk), 0);

    // Clean sig edges
    repeat (3) step();
    chk("t5_quiet_pe", int'(pe), 0);
    chk("t5_quiet_ne", int'(ne), 0);
    sig_drv = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("t5_rise_pe", int'(pe), (i == 2) ? 1 : 0);
      chk("t5_rise_ne", int'(ne), 0);
    end
    sig_drv = 1'b0;
    for (int i = 4; i <= 7; i++) begin
      step();
      chk("t5_fall_ne", int'(ne), (i == 5) ? 1 : 0);
      chk("t5_fall_pe", int'(pe), 0);
    end

    // Half-cycle glitch straddling one rising edge
    #7 sig_drv = 1'b1;
    @(posedge clk);
    #3 sig_drv = 1'b0;
    pe_cnt = 0; ne_cnt = 0; overlap = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      pe_cnt += int'(pe);
      ne_cnt += int'(ne);
      overlap += int'(pe & ne);
    end
    chk("glitch_pe_cnt", pe_cnt, 1);
    chk("glitch_ne_cnt", ne_cnt, 1);
    chk("glitch_overlap", overlap, 0);

    // Asynchronous reset mid-transfer with sclk and pe high
    divider = 3'd2; cpol = 1'b0;
    step();
    cs = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 3) sig_drv = 1'b1;
    end
    chk("pre_rst_sclk", int'(sclk), 1);
    chk("pre_rst_pe", int'(pe), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_sclk", int'(sclk), 0);
    chk("arst_pe", int'(pe), 0);
    chk("arst_ne", int'(ne), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("post_rst_sclk", int'(sclk), (i >= 4) ? 1 : 0);
      chk("post_rst_pe", int'(pe), (i == 2) ? 1 : 0);
      chk("post_rst_ne", int'(ne), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
